gpin_conditioner: RTL and testbench

GPIN_CONDITIONER -- requirements
Module: gpin_conditioner

---
 rtl/gpin_conditioner.sv | 105 ++++++++++
 tb/tb_gpin_conditioner.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpin_conditioner.sv
// Debounces 16 asynchronous field inputs on a prescaled tick and reports level changes.
// Define GPIN_EDGE_LATCH_EN to build the sticky rising-edge flags on edge_out.
module gpin_conditioner #(
  parameter int DIV        = 1000,
  parameter int STABLE_CNT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] raw_in,
  input  logic        clr_edges,
  input  logic [15:0] clr_mask,
  output logic [15:0] level_out,
  output logic [15:0] edge_out,
  output logic        change
);

  localparam logic [15:0] DIV_LAST = 16'(DIV - 1);
  localparam logic [2:0]  CNT_LAST = 3'(STABLE_CNT - 1);

  logic [15:0]       sync_p0;
  logic [15:0]       sync_p1;
  logic [15:0]       presc;
  logic              tick;
  logic [15:0][2:0]  stab_cnt;
  logic [15:0][2:0]  stab_cnt_nxt;
  logic [15:0]       level_nxt;

  // Stage p0/p1: two-flop synchronizer on every field input
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= raw_in;
      sync_p1 <= sync_p0;
    end
  end

  assign tick = (presc == DIV_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) presc <= '0;
    else     presc <= tick ? 16'd0 : presc + 16'd1;
  end

  // A bit flips only after STABLE_CNT consecutive ticks disagree with the current level
  always_comb begin
    level_nxt    = level_out;
    stab_cnt_nxt = stab_cnt;
    for (int i = 0; i < 16; i++) begin
      if (tick) begin
        if (sync_p1[i] == level_out[i]) begin
          stab_cnt_nxt[i] = 3'd0;
        end else if (stab_cnt[i] >= CNT_LAST) begin
          level_nxt[i]    = sync_p1[i];
          stab_cnt_nxt[i] = 3'd0;
        end else begin
          stab_cnt_nxt[i] = stab_cnt[i] + 3'd1;
        end
      end
    end
  end

  // Stage p2: debounced level and its change strobe land on the same edge
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stab_cnt  <= '0;
      level_out <= '0;
      change    <= 1'b0;
    end else begin
      stab_cnt  <= stab_cnt_nxt;
      level_out <= level_nxt;
      change    <= |(level_nxt ^ level_out);
    end
  end

`ifdef GPIN_EDGE_LATCH_EN
  logic [15:0] level_d;
  logic [15:0] edge_q;
  logic [15:0] rise;
  logic [15:0] clr_sel;

  assign rise    = level_out & ~level_d;
  assign clr_sel = clr_edges ? clr_mask : 16'h0000;

  // Set is OR-ed in after the clear so a simultaneous rise keeps its flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      level_d <= '0;
      edge_q  <= '0;
    end else begin
      level_d <= level_out;
      edge_q  <= (edge_q & ~clr_sel) | rise;
    end
  end

  assign edge_out = edge_q;
`else
  logic unused_clr;

  assign unused_clr = clr_edges ^ (^clr_mask);
  assign edge_out   = 16'h0000;
`endif

endmodule

// File: tb/tb_gpin_conditioner.sv
// Scoreboard bench for gpin_conditioner at DIV=4, STABLE_CNT=3; edge expectations
// follow whether GPIN_EDGE_LATCH_EN is defined for the build.
module tb_gpin_conditioner;

  localparam int DIV = 4;
  localparam int SC  = 3;
`ifdef GPIN_EDGE_LATCH_EN
  localparam bit EDGE_EN = 1'b1;
`else
  localparam bit EDGE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] raw_in = '0;
  logic        clr_edges = 1'b0;
  logic [15:0] clr_mask = '0;
  logic [15:0] level_out;
  logic [15:0] edge_out;
  logic        change;

  gpin_conditioner #(.DIV(DIV), .STABLE_CNT(SC)) dut (
    .clk       (clk),
    .rst       (rst),
    .raw_in    (raw_in),
    .clr_edges (clr_edges),
    .clr_mask  (clr_mask),
    .level_out (level_out),
    .edge_out  (edge_out),
    .change    (change)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] lvl;
    logic [15:0] edg;
    int          cyc;
  } exp_t;

  exp_t        sb[$];
  int          cyc;
  int          n_checks = 0;
  int          n_fail = 0;
  logic [15:0] exp_level = '0;
  logic [15:0] exp_edge = '0;
  bit          edge_pending = 1'b0;
  logic [15:0] pend_edge = '0;

  // Cycles since reset release; tick effects land on edges where cyc is a multiple of DIV
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Raw applied in cycle c is seen by ticks at t >= c+3; the SC-th such tick moves the level
  task automatic push_raw(input logic [15:0] nr, input int c);
    exp_t e;
    int   ft;
    ft    = ((c + 3 + DIV - 1) / DIV) * DIV;
    e.cyc = ft + (SC - 1) * DIV;
    e.lvl = nr;
    e.edg = EDGE_EN ? (exp_edge | (nr & ~exp_level)) : 16'h0000;
    exp_level = nr;
    exp_edge  = e.edg;
    sb.push_back(e);
    raw_in = nr;
  endtask

  task automatic drive_raw(input logic [15:0] nr);
    @(posedge clk);
    #1;
    push_raw(nr, cyc);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || edge_pending) && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    check_eq("drain_timeout", sb.size() + int'(edge_pending), 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (edge_pending) begin
          check_eq("edge_out", int'(edge_out), int'(pend_edge));
          check_eq("change_width", int'(change), 0);
          edge_pending = 1'b0;
        end
        if (change) begin
          if (sb.size() == 0) begin
            check_eq("unexpected_change", int'(level_out), int'(exp_level) ^ 32'h10000);
          end else begin
            e = sb.pop_front();
            check_eq("level_out", int'(level_out), int'(e.lvl));
            check_eq("change_cycle", cyc, e.cyc);
            pend_edge    = e.edg;
            edge_pending = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int c;
    int ft;
    int target;
    int n;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_level", int'(level_out), 0);
    check_eq("rst_edge", int'(edge_out), 0);
    check_eq("rst_change", int'(change), 0);
    @(negedge clk);
    rst = 1'b0;
    push_raw(16'h0001, 0);
    wait_drain();

    // bit3 glitch spanning exactly two ticks
    @(posedge clk);
    #1;
    raw_in[3] = 1'b1;
    repeat (2 * DIV) @(posedge clk);
    #1;
    raw_in[3] = 1'b0;
    repeat (6 * DIV) @(posedge clk);
    #1;
    check_eq("glitch_level", int'(level_out), int'(exp_level));
    check_eq("glitch_edge", int'(edge_out), int'(exp_edge));

    drive_raw(16'h0005);
    wait_drain();

    @(posedge clk);
    #1;
    clr_edges = 1'b1;
    clr_mask  = 16'h0001;
    @(posedge clk);
    #1;
    clr_edges = 1'b0;
    clr_mask  = 16'h0000;
    exp_edge  = exp_edge & ~16'h0001;
    check_eq("clr_edge", int'(edge_out), int'(exp_edge));
    check_eq("clr_level", int'(level_out), int'(exp_level));

    // bit3 needs the full count after its earlier glitch
    drive_raw(16'h000D);
    wait_drain();
    drive_raw(16'h000C);
    wait_drain();

    // rise of bit0 and clear of bit0 hit the same edge
    drive_raw(16'h000D);
    target = sb[$].cyc;
    n = 0;
    while (cyc < target && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_eq("collide_change", int'(change), 1);
    clr_edges = 1'b1;
    clr_mask  = 16'h0001;
    @(posedge clk);
    #1;
    clr_edges = 1'b0;
    clr_mask  = 16'h0000;
    wait_drain();

    // asynchronous reset after two of three ticks
    @(posedge clk);
    #1;
    c = cyc;
    raw_in = 16'h001D;
    ft = ((c + 3 + DIV - 1) / DIV) * DIV;
    n = 0;
    while (cyc < ft + DIV && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_level", int'(level_out), 0);
    check_eq("async_rst_edge", int'(edge_out), 0);
    check_eq("async_rst_change", int'(change), 0);
    exp_level = '0;
    exp_edge  = '0;
    edge_pending = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    push_raw(16'h001D, 0);
    wait_drain();

    drive_raw(16'hFFFF);
    wait_drain();
    repeat (10) @(posedge clk);
    #1;
    check_eq("final_level", int'(level_out), int'(exp_level));
    check_eq("final_edge", int'(edge_out), int'(exp_edge));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
